// File: rtl/lab1_imul_client.sv
// imul request/response initiator: forwards {a,b} requests, checks returned products in order against golden values.
// Optional LAB1_IMUL_CLIENT_RANDOM_DELAY_EN adds LFSR response back-pressure and a stall_cycles counter.
module lab1_imul_client #(
    parameter int p_nbits        = 32,
    parameter int p_max_inflight = 4,
    parameter int p_cnt_nbits    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [p_cnt_nbits-1:0] cfg_num_msgs,
    input  logic                   src_val,
    output logic                   src_rdy,
    input  logic [p_nbits-1:0]     src_a,
    input  logic [p_nbits-1:0]     src_b,
    input  logic [p_nbits-1:0]     src_ref,
    output logic                   req_val,
    input  logic                   req_rdy,
    output logic [2*p_nbits-1:0]   req_msg,
    input  logic                   resp_val,
    output logic                   resp_rdy,
    input  logic [p_nbits-1:0]     resp_msg,
    output logic [p_cnt_nbits-1:0] num_sent,
    output logic [p_cnt_nbits-1:0] num_recv,
    output logic [p_cnt_nbits-1:0] num_errors,
    output logic [p_cnt_nbits-1:0] first_err_idx,
    output logic                   proto_err,
    output logic                   done
`ifdef LAB1_IMUL_CLIENT_RANDOM_DELAY_EN
    ,
    output logic [p_cnt_nbits-1:0] stall_cycles
`endif
);

    localparam int c_ptr_nbits = $clog2(p_max_inflight);
    localparam int c_occ_nbits = c_ptr_nbits + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [c_ptr_nbits-1:0] c_ptr_one = 1;
    localparam logic [c_occ_nbits-1:0] c_occ_one = 1;
    localparam logic [c_occ_nbits-1:0] c_depth   = c_occ_nbits'(p_max_inflight);
    localparam logic [p_cnt_nbits-1:0] c_cnt_one = 1;

    logic [1:0]             state_q, state_d;
    logic [p_cnt_nbits-1:0] num_total_q, num_total_d;
    logic [p_cnt_nbits-1:0] num_sent_q, num_sent_d;
    logic [p_cnt_nbits-1:0] num_recv_q, num_recv_d;
    logic [p_cnt_nbits-1:0] num_errors_q, num_errors_d;
    logic [p_cnt_nbits-1:0] first_err_idx_q, first_err_idx_d;
    logic                   proto_err_q, proto_err_d;
    logic [c_ptr_nbits-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_nbits-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_occ_nbits-1:0] occ_q, occ_d;
    logic [p_nbits-1:0]     fifo_q [p_max_inflight];

    logic in_run, in_resp_phase, start_ok;
    logic fifo_empty, can_issue, src_fire, resp_fire, mismatch, proto_hit;
    logic resp_gate;
    logic [p_nbits-1:0] fifo_head;

    assign in_run        = (state_q == ST_RUN);
    assign in_resp_phase = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign start_ok      = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign fifo_empty    = (occ_q == '0);
    assign fifo_head     = fifo_q[rd_ptr_q];

    // Full FIFO blocks issue even if a pop happens this cycle: no bypass.
    assign can_issue = in_run && (occ_q < c_depth) && (num_sent_q < num_total_q);

    assign req_msg  = {src_a, src_b};
    assign req_val  = src_val && can_issue;
    assign src_rdy  = req_rdy && can_issue;
    assign src_fire = src_val && src_rdy;

`ifdef LAB1_IMUL_CLIENT_RANDOM_DELAY_EN
    logic [15:0]            lfsr_q, lfsr_d;
    logic [p_cnt_nbits-1:0] stall_cycles_q, stall_cycles_d;
    logic                   lfsr_fb;

    assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign lfsr_d    = {lfsr_q[14:0], lfsr_fb};
    assign resp_gate = lfsr_q[0];

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (start_ok) begin
            stall_cycles_d = '0;
        end else if (in_resp_phase && resp_val && !fifo_empty && !lfsr_q[0]
                     && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + c_cnt_one;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q         <= 16'hACE1;
            stall_cycles_q <= '0;
        end else begin
            lfsr_q         <= lfsr_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`else
    assign resp_gate = 1'b1;
`endif

    assign resp_rdy  = in_resp_phase && !fifo_empty && resp_gate;
    assign resp_fire = resp_val && resp_rdy;
    assign mismatch  = (resp_msg != fifo_head);
    // A response with nothing outstanding is flagged but left unconsumed.
    assign proto_hit = in_resp_phase && resp_val && fifo_empty;

    always_comb begin
        state_d         = state_q;
        num_total_d     = num_total_q;
        num_sent_d      = num_sent_q;
        num_recv_d      = num_recv_q;
        num_errors_d    = num_errors_q;
        first_err_idx_d = first_err_idx_q;
        proto_err_d     = proto_err_q || proto_hit;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        occ_d           = occ_q;

        if (start_ok) begin
            num_total_d     = cfg_num_msgs;
            num_sent_d      = '0;
            num_recv_d      = '0;
            num_errors_d    = '0;
            first_err_idx_d = '1;
            wr_ptr_d        = '0;
            rd_ptr_d        = '0;
            occ_d           = '0;
            state_d         = (cfg_num_msgs == '0) ? ST_DONE : ST_RUN;
        end else begin
            if (src_fire) begin
                wr_ptr_d   = wr_ptr_q + c_ptr_one;
                num_sent_d = num_sent_q + c_cnt_one;
            end
            if (resp_fire) begin
                rd_ptr_d   = rd_ptr_q + c_ptr_one;
                num_recv_d = num_recv_q + c_cnt_one;
                if (mismatch) begin
                    if (num_errors_q == '0) begin
                        first_err_idx_d = num_recv_q;
                    end
                    if (num_errors_q != '1) begin
                        num_errors_d = num_errors_q + c_cnt_one;
                    end
                end
            end
            case ({src_fire, resp_fire})
                2'b10:   occ_d = occ_q + c_occ_one;
                2'b01:   occ_d = occ_q - c_occ_one;
                default: occ_d = occ_q;
            endcase
            case (state_q)
                ST_RUN: begin
                    if (num_sent_q == num_total_q) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (num_recv_d == num_total_q) begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            num_total_q     <= '0;
            num_sent_q      <= '0;
            num_recv_q      <= '0;
            num_errors_q    <= '0;
            first_err_idx_q <= '1;
            proto_err_q     <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            occ_q           <= '0;
        end else begin
            state_q         <= state_d;
            num_total_q     <= num_total_d;
            num_sent_q      <= num_sent_d;
            num_recv_q      <= num_recv_d;
            num_errors_q    <= num_errors_d;
            first_err_idx_q <= first_err_idx_d;
            proto_err_q     <= proto_err_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            occ_q           <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (src_fire) begin
            fifo_q[wr_ptr_q] <= src_ref;
        end
    end

    assign num_sent      = num_sent_q;
    assign num_recv      = num_recv_q;
    assign num_errors    = num_errors_q;
    assign first_err_idx = first_err_idx_q;
    assign proto_err     = proto_err_q;
    assign done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_lab1_imul_client.sv
// Randomized bench for lab1_imul_client: a queue-based multiplier/source model drives the block and predicts its counters.
module tb_lab1_imul_client;

    localparam int NB    = 32;
    localparam int P_INF = 4;
    localparam int CN    = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [CN-1:0]     cfg_num_msgs = '0;
    logic              src_val = 1'b0;
    logic              src_rdy;
    logic [NB-1:0]     src_a = '0, src_b = '0, src_ref = '0;
    logic              req_val;
    logic              req_rdy = 1'b0;
    logic [2*NB-1:0]   req_msg;
    logic              resp_val = 1'b0;
    logic              resp_rdy;
    logic [NB-1:0]     resp_msg = '0;
    logic [CN-1:0]     num_sent, num_recv, num_errors, first_err_idx;
    logic              proto_err, done;
`ifdef LAB1_IMUL_CLIENT_RANDOM_DELAY_EN
    logic [CN-1:0]     stall_cycles;
`endif

    lab1_imul_client #(.p_nbits(NB), .p_max_inflight(P_INF), .p_cnt_nbits(CN)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_num_msgs(cfg_num_msgs),
        .src_val(src_val), .src_rdy(src_rdy), .src_a(src_a), .src_b(src_b), .src_ref(src_ref),
        .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
        .num_sent(num_sent), .num_recv(num_recv), .num_errors(num_errors),
        .first_err_idx(first_err_idx), .proto_err(proto_err), .done(done)
`ifdef LAB1_IMUL_CLIENT_RANDOM_DELAY_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit exp_proto = 1'b0;
    int last_max_out = 0;

    logic [NB-1:0] ta[$];
    logic [NB-1:0] tb[$];
    logic [NB-1:0] mq_prod[$];
    int            mq_rdy[$];
    logic [NB-1:0] fix_a[3] = '{32'd3, 32'd2, 32'd5};
    logic [NB-1:0] fix_b[3] = '{32'd4, 32'd3, 32'd7};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input int n);
        @(posedge clk); #1;
        start = 1'b1;
        cfg_num_msgs = n[CN-1:0];
        src_val = 1'b0;
        resp_val = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        cyc++;
    endtask

    // One run: random source/ready timing, pipelined multiplier model with a fixed latency.
    task automatic run_msgs(input int n, input int delay, input int bad_idx, input int src_prob,
                            input int rdy_prob, input bit fixed_ops, input bit proto_pulse,
                            input int stop_sent);
        int src_idx, nresp, outstanding, max_out;
        bit first, sf, rf;
        logic [NB-1:0] p;
        ta.delete(); tb.delete(); mq_prod.delete(); mq_rdy.delete();
        for (int i = 0; i < n; i++) begin
            ta.push_back(fixed_ops ? fix_a[i % 3] : NB'($urandom));
            tb.push_back(fixed_ops ? fix_b[i % 3] : NB'($urandom));
        end
        src_idx = 0; nresp = 0; outstanding = 0; max_out = 0; first = proto_pulse;
        do_start(n);
        for (int k = 0; k < 4000; k++) begin
            if (src_idx < n) begin
                src_val = !first && ($urandom_range(0, 99) < src_prob);
                src_a = ta[src_idx];
                src_b = tb[src_idx];
                p = ta[src_idx] * tb[src_idx];
                src_ref = p;
            end else begin
                src_val = 1'b1;
            end
            req_rdy = ($urandom_range(0, 99) < rdy_prob);
            if (mq_prod.size() > 0 && mq_rdy[0] <= cyc) begin
                resp_val = 1'b1;
                resp_msg = (nresp == bad_idx) ? 32'hDEADBEEF : mq_prod[0];
            end else begin
                resp_val = first;
                resp_msg = NB'($urandom);
            end
            @(negedge clk);
            if (done) break;
            if (first) check("proto_not_consumed", {63'd0, resp_rdy}, 64'd0);
            if (req_val && src_idx < n) check("req_msg", req_msg, {ta[src_idx], tb[src_idx]});
            if (src_idx >= n) check("no_req_after_total", {63'd0, req_val}, 64'd0);
            if (outstanding == P_INF) check("src_rdy_full", {63'd0, src_rdy}, 64'd0);
`ifndef LAB1_IMUL_CLIENT_RANDOM_DELAY_EN
            check("resp_rdy", {63'd0, resp_rdy}, {63'd0, outstanding != 0});
`endif
            sf = src_val && src_rdy;
            rf = resp_val && resp_rdy;
            if (sf && src_idx < n) begin
                p = ta[src_idx] * tb[src_idx];
                mq_prod.push_back(p);
                mq_rdy.push_back(cyc + delay);
                src_idx++;
                outstanding++;
            end
            if (rf && mq_prod.size() > 0) begin
                void'(mq_prod.pop_front());
                void'(mq_rdy.pop_front());
                nresp++;
                outstanding--;
            end
            if (sf) check("inflight_bound", {63'd0, outstanding <= P_INF}, 64'd1);
            if (outstanding > max_out) max_out = outstanding;
            first = 1'b0;
            @(posedge clk); #1;
            cyc++;
            if (stop_sent > 0 && src_idx == stop_sent) return;
        end
        last_max_out = max_out;
        src_val = 1'b0;
        resp_val = 1'b0;
        check("done", {63'd0, done}, 64'd1);
        check("num_sent", {48'd0, num_sent}, 64'(n));
        check("num_recv", {48'd0, num_recv}, 64'(n));
        check("num_errors", {48'd0, num_errors}, (bad_idx >= 0 && bad_idx < n) ? 64'd1 : 64'd0);
        check("first_err_idx", {48'd0, first_err_idx},
              (bad_idx >= 0 && bad_idx < n) ? 64'(bad_idx) : 64'hFFFF);
        check("proto_err", {63'd0, proto_err}, {63'd0, exp_proto});
        check("model_drained", 64'(nresp), 64'(n));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_num_sent", {48'd0, num_sent}, 64'd0);
        check("rst_num_recv", {48'd0, num_recv}, 64'd0);
        check("rst_num_errors", {48'd0, num_errors}, 64'd0);
        check("rst_first_err", {48'd0, first_err_idx}, 64'hFFFF);
        check("rst_proto", {63'd0, proto_err}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);

        run_msgs(1, 1, -1, 100, 100, 1'b1, 1'b0, 0);
        run_msgs(8, 34, -1, 100, 100, 1'b0, 1'b0, 0);
        check("fifo_filled", 64'(last_max_out), 64'(P_INF));
        run_msgs(3, 3, 1, 100, 100, 1'b1, 1'b0, 0);

        // Zero-length run: straight to DONE, no request ever offered.
        do_start(0);
        for (int k = 0; k < 3; k++) begin
            src_val = 1'b1; req_rdy = 1'b1;
            @(negedge clk);
            check("zero_done", {63'd0, done}, 64'd1);
            check("zero_no_req", {63'd0, req_val}, 64'd0);
            check("zero_num_sent", {48'd0, num_sent}, 64'd0);
            @(posedge clk); #1; cyc++;
        end
        src_val = 1'b0;

        // Reset mid-run after two requests.
        run_msgs(5, 34, -1, 100, 100, 1'b0, 1'b0, 2);
        reset = 1'b1; src_val = 1'b1; req_rdy = 1'b1; resp_val = 1'b1;
        @(posedge clk); #1; reset = 1'b0; cyc++;
        @(negedge clk);
        check("mid_rst_sent", {48'd0, num_sent}, 64'd0);
        check("mid_rst_recv", {48'd0, num_recv}, 64'd0);
        check("mid_rst_done", {63'd0, done}, 64'd0);
        check("mid_rst_src_rdy", {63'd0, src_rdy}, 64'd0);
        check("mid_rst_resp_rdy", {63'd0, resp_rdy}, 64'd0);
        check("mid_rst_first_err", {48'd0, first_err_idx}, 64'hFFFF);
        src_val = 1'b0; resp_val = 1'b0;
        run_msgs(4, 5, -1, 80, 80, 1'b0, 1'b0, 0);

        // Stray response before any request, then a fresh run keeps the sticky flag.
        exp_proto = 1'b1;
        run_msgs(2, 2, -1, 100, 100, 1'b0, 1'b1, 0);
        run_msgs(6, 7, -1, 60, 70, 1'b0, 1'b0, 0);

        for (int r = 0; r < 5; r++) begin
            n = $urandom_range(1, 12);
            bad = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1;
            run_msgs(n, $urandom_range(1, 12), bad, $urandom_range(40, 100),
                     $urandom_range(40, 100), 1'b0, 1'b0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
